// File: rtl/add_rs_pkg.sv
// Shared encodings for the add/sub reservation station.
package add_rs_pkg;

  // ALU operation encodings carried with each entry.
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Tag value meaning "operand value already valid".
  localparam int unsigned TAG_NONE = 0;

  // Default geometry of the station.
  localparam int unsigned RS_ENTRIES_DEF  = 3;
  localparam int unsigned RS_TAG_W_DEF    = 3;
  localparam int unsigned RS_DATA_W_DEF   = 32;
  localparam int unsigned RS_BASE_TAG_DEF = 1;

  // Per-entry lifecycle, named apart from the ALU's own state encodings.
  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/add_rs_if.sv
// Issue, CDB and ALU-dispatch signals of the add/sub reservation station.
interface add_rs_if #(
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32
) ();

  // Issue side
  logic              issueEN;
  logic              issueOp;
  logic [TAG_W-1:0]  issueQj;
  logic [DATA_W-1:0] issueVj;
  logic [TAG_W-1:0]  issueQk;
  logic [DATA_W-1:0] issueVk;
  logic              issueReady;
  logic [TAG_W-1:0]  issueTag;

  // Common data bus
  logic              cdbValid;
  logic [TAG_W-1:0]  cdbTag;
  logic [DATA_W-1:0] cdbData;

  // ALU dispatch side
  logic              aluAvailable;
  logic              aluEN;
  logic              aluOp;
  logic [DATA_W-1:0] aluData1;
  logic [DATA_W-1:0] aluData2;
  logic [TAG_W-1:0]  aluTag;

  // Environment driving the station: issue logic, CDB and ALU.
  modport master (
    output issueEN, issueOp, issueQj, issueVj, issueQk, issueVk,
    input  issueReady, issueTag,
    output cdbValid, cdbTag, cdbData,
    output aluAvailable,
    input  aluEN, aluOp, aluData1, aluData2, aluTag
  );

  // The reservation station itself.
  modport slave (
    input  issueEN, issueOp, issueQj, issueVj, issueQk, issueVk,
    output issueReady, issueTag,
    input  cdbValid, cdbTag, cdbData,
    input  aluAvailable,
    output aluEN, aluOp, aluData1, aluData2, aluTag
  );

endinterface

// File: rtl/add_rs_rs_entry.sv
// One reservation-station entry: holds op/Q/V, snoops the CDB, tracks lifecycle.
module rs_entry
  import add_rs_pkg::*;
#(
  parameter int unsigned TAG_W  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MY_TAG = 1
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              alloc,
  input  logic              dispatch,
  input  logic              issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ready,
  output logic              free,
  output logic              op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);

  localparam logic [TAG_W-1:0] OWN_TAG = TAG_W'(MY_TAG);
  localparam logic [TAG_W-1:0] NO_TAG  = TAG_W'(TAG_NONE);

  rs_state_e         state_q, state_d;
  logic              op_q, op_d;
  logic [TAG_W-1:0]  qj_q, qj_d, qk_q, qk_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;

  logic fwd_j, fwd_k, hit_j, hit_k, own_hit;

  // CDB compares: forwarding into a new issue, wakeup of stored tags, own completion.
  assign fwd_j   = cdb_valid && (issue_qj != NO_TAG) && (cdb_tag == issue_qj);
  assign fwd_k   = cdb_valid && (issue_qk != NO_TAG) && (cdb_tag == issue_qk);
  assign hit_j   = cdb_valid && (qj_q != NO_TAG) && (cdb_tag == qj_q);
  assign hit_k   = cdb_valid && (qk_q != NO_TAG) && (cdb_tag == qk_q);
  assign own_hit = cdb_valid && (cdb_tag == OWN_TAG);

  // Next-state and field-update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    qj_d    = qj_q;
    vj_d    = vj_q;
    qk_d    = qk_q;
    vk_d    = vk_q;
    case (state_q)
      RS_FREE: begin
        if (alloc) begin
          op_d    = issue_op;
          qj_d    = fwd_j ? NO_TAG : issue_qj;
          vj_d    = fwd_j ? cdb_data : issue_vj;
          qk_d    = fwd_k ? NO_TAG : issue_qk;
          vk_d    = fwd_k ? cdb_data : issue_vk;
          state_d = ((qj_d == NO_TAG) && (qk_d == NO_TAG)) ? RS_READY : RS_WAIT;
        end
      end
      RS_WAIT: begin
        if (hit_j) begin
          qj_d = NO_TAG;
          vj_d = cdb_data;
        end
        if (hit_k) begin
          qk_d = NO_TAG;
          vk_d = cdb_data;
        end
        if ((qj_d == NO_TAG) && (qk_d == NO_TAG)) begin
          state_d = RS_READY;
        end
      end
      RS_READY: begin
        if (dispatch) begin
          state_d = RS_EXEC;
        end
      end
      RS_EXEC: begin
        // Stays busy until its own result is broadcast.
        if (own_hit) begin
          state_d = RS_FREE;
        end
      end
    endcase
  end

  // State and field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q <= RS_FREE;
      op_q    <= ALU_ADD;
      qj_q    <= NO_TAG;
      vj_q    <= '0;
      qk_q    <= NO_TAG;
      vk_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      qj_q    <= qj_d;
      vj_q    <= vj_d;
      qk_q    <= qk_d;
      vk_q    <= vk_d;
    end
  end

  assign ready = (state_q == RS_READY);
  assign free  = (state_q == RS_FREE);
  assign op    = op_q;
  assign vj    = vj_q;
  assign vk    = vk_q;

endmodule

// File: rtl/add_rs.sv
// Add/sub reservation station: allocate on issue, wake on CDB, dispatch to ALU.
module add_rs
  import add_rs_pkg::*;
#(
  parameter int unsigned ENTRIES  = RS_ENTRIES_DEF,
  parameter int unsigned TAG_W    = RS_TAG_W_DEF,
  parameter int unsigned DATA_W   = RS_DATA_W_DEF,
  parameter int unsigned BASE_TAG = RS_BASE_TAG_DEF
) (
  input logic    clk,
  input logic    RST,
  add_rs_if.slave bus
);

  logic [ENTRIES-1:0] free_v;
  logic [ENTRIES-1:0] ready_v;
  logic [ENTRIES-1:0] alloc_v;
  logic [ENTRIES-1:0] disp_v;
  logic [ENTRIES-1:0] op_v;
  logic [DATA_W-1:0]  vj_v [ENTRIES];
  logic [DATA_W-1:0]  vk_v [ENTRIES];

  logic [ENTRIES-1:0] alloc_oh, disp_oh;
  logic               alloc_hit, disp_hit;
  logic [TAG_W-1:0]   alloc_tag;
  logic               alu_en_c, alu_op_c;
  logic [DATA_W-1:0]  alu_d1_c, alu_d2_c;
  logic [TAG_W-1:0]   alu_tag_c;

  // Lowest-index free entry; depends on registered state only.
  always_comb begin
    alloc_oh  = '0;
    alloc_hit = 1'b0;
    alloc_tag = TAG_W'(TAG_NONE);
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (free_v[i]) begin
        alloc_oh    = '0;
        alloc_oh[i] = 1'b1;
        alloc_hit   = 1'b1;
        alloc_tag   = TAG_W'(BASE_TAG + 32'(i));
      end
    end
  end

  // Lowest-index ready entry.
  always_comb begin
    disp_oh  = '0;
    disp_hit = 1'b0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (ready_v[i]) begin
        disp_oh    = '0;
        disp_oh[i] = 1'b1;
        disp_hit   = 1'b1;
      end
    end
  end

  assign alloc_v  = (bus.issueEN && alloc_hit) ? alloc_oh : '0;
  assign alu_en_c = bus.aluAvailable && disp_hit;
  assign disp_v   = alu_en_c ? disp_oh : '0;

  // Dispatch mux; all fields zero when nothing is dispatched.
  always_comb begin
    alu_op_c  = ALU_ADD;
    alu_d1_c  = '0;
    alu_d2_c  = '0;
    alu_tag_c = TAG_W'(TAG_NONE);
    for (int i = 0; i < int'(ENTRIES); i++) begin
      if (disp_v[i]) begin
        alu_op_c  = op_v[i];
        alu_d1_c  = vj_v[i];
        alu_d2_c  = vk_v[i];
        alu_tag_c = TAG_W'(BASE_TAG + 32'(i));
      end
    end
  end

  // One entry per tag, BASE_TAG upward.
  for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_entry
    rs_entry #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .MY_TAG (BASE_TAG + g)
    ) u_entry (
      .clk       (clk),
      .RST       (RST),
      .alloc     (alloc_v[g]),
      .dispatch  (disp_v[g]),
      .issue_op  (bus.issueOp),
      .issue_qj  (bus.issueQj),
      .issue_vj  (bus.issueVj),
      .issue_qk  (bus.issueQk),
      .issue_vk  (bus.issueVk),
      .cdb_valid (bus.cdbValid),
      .cdb_tag   (bus.cdbTag),
      .cdb_data  (bus.cdbData),
      .ready     (ready_v[g]),
      .free      (free_v[g]),
      .op        (op_v[g]),
      .vj        (vj_v[g]),
      .vk        (vk_v[g])
    );
  end

  assign bus.issueReady = alloc_hit;
  assign bus.issueTag   = alloc_tag;
  assign bus.aluEN      = alu_en_c;
  assign bus.aluOp      = alu_op_c;
  assign bus.aluData1   = alu_d1_c;
  assign bus.aluData2   = alu_d2_c;
  assign bus.aluTag     = alu_tag_c;

endmodule

// File: tb/tb_add_rs.sv
// Self-checking bench for add_rs: directed plan steps, then randomized traffic vs a reference model.
module tb_add_rs;

  localparam int N = 3;

  logic clk = 1'b0;
  logic RST;

  add_rs_if #(.TAG_W(3), .DATA_W(32)) bus ();

  add_rs #(.ENTRIES(3), .TAG_W(3), .DATA_W(32), .BASE_TAG(1)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: one record per tag (tag = index + 1).
  bit          m_busy [N];
  bit          m_sent [N];
  bit          m_op   [N];
  int          m_qj   [N];
  int          m_qk   [N];
  logic [31:0] m_vj   [N];
  logic [31:0] m_vk   [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_sent[i] = 0; m_op[i] = 0;
      m_qj[i] = 0; m_qk[i] = 0; m_vj[i] = 0; m_vk[i] = 0;
    end
  endtask

  function automatic int first_free();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int i = 0; i < N; i++)
      if (m_busy[i] && !m_sent[i] && m_qj[i] == 0 && m_qk[i] == 0) return i;
    return -1;
  endfunction

  // Compare all outputs against what the model says for the current inputs.
  task automatic check_outputs();
    int f, r;
    bit en;
    f  = first_free();
    r  = first_ready();
    en = bus.aluAvailable && (r >= 0);
    chk("issueReady", 32'(bus.issueReady), 32'(f >= 0));
    chk("issueTag",   32'(bus.issueTag),   32'((f >= 0) ? f + 1 : 0));
    chk("aluEN",      32'(bus.aluEN),      32'(en));
    chk("aluOp",      32'(bus.aluOp),      en ? 32'(m_op[r]) : 32'd0);
    chk("aluData1",   bus.aluData1,        en ? m_vj[r] : 32'd0);
    chk("aluData2",   bus.aluData2,        en ? m_vk[r] : 32'd0);
    chk("aluTag",     32'(bus.aluTag),     en ? 32'(r + 1) : 32'd0);
  endtask

  // Apply one clock edge's worth of events to the model, using the inputs held during the cycle.
  task automatic model_edge();
    int  a, d, ct;
    bit  cv;
    logic [31:0] cd;
    if (RST) begin
      model_clear();
      return;
    end
    a  = first_free();
    d  = first_ready();
    cv = bus.cdbValid;
    ct = int'(bus.cdbTag);
    cd = bus.cdbData;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i] && m_sent[i] && cv && ct == i + 1) begin
        m_busy[i] = 0;
        m_sent[i] = 0;
      end else if (m_busy[i] && !m_sent[i]) begin
        if (cv && m_qj[i] != 0 && ct == m_qj[i]) begin m_qj[i] = 0; m_vj[i] = cd; end
        if (cv && m_qk[i] != 0 && ct == m_qk[i]) begin m_qk[i] = 0; m_vk[i] = cd; end
      end
    end
    if (d >= 0 && bus.aluAvailable) m_sent[d] = 1;
    if (a >= 0 && bus.issueEN) begin
      m_busy[a] = 1;
      m_sent[a] = 0;
      m_op[a]   = bus.issueOp;
      m_qj[a]   = int'(bus.issueQj);
      m_vj[a]   = bus.issueVj;
      m_qk[a]   = int'(bus.issueQk);
      m_vk[a]   = bus.issueVk;
      if (cv && m_qj[a] != 0 && ct == m_qj[a]) begin m_qj[a] = 0; m_vj[a] = cd; end
      if (cv && m_qk[a] != 0 && ct == m_qk[a]) begin m_qk[a] = 0; m_vk[a] = cd; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit en, input bit op, input int qj, input logic [31:0] vj,
                       input int qk, input logic [31:0] vk, input bit cv, input int ct,
                       input logic [31:0] cd, input bit av);
    bus.issueEN      = en;
    bus.issueOp      = op;
    bus.issueQj      = 3'(qj);
    bus.issueVj      = vj;
    bus.issueQk      = 3'(qk);
    bus.issueVk      = vk;
    bus.cdbValid     = cv;
    bus.cdbTag       = 3'(ct);
    bus.cdbData      = cd;
    bus.aluAvailable = av;
  endtask

  task automatic idle(input bit av);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, av);
  endtask

  task automatic bcast(input int ct, input logic [31:0] cd);
    drive(0, 0, 0, 0, 0, 0, 1, ct, cd, 1);
  endtask

  initial begin
    model_clear();
    RST = 1'b1;
    idle(0);
    @(posedge clk);
    model_edge();
    #1;
    RST = 1'b0;

    // Reset state
    idle(0); #2;
    chk("rst_issueReady", 32'(bus.issueReady), 32'd1);
    chk("rst_issueTag",   32'(bus.issueTag),   32'd1);
    chk("rst_aluEN",      32'(bus.aluEN),      32'd0);
    chk("rst_aluData1",   bus.aluData1,        32'd0);
    tick();

    // 1: ready-operand add dispatches next cycle, frees on own tag
    drive(1, 0, 0, 5, 0, 7, 0, 0, 0, 1); #2;
    chk("t1_issueTag", 32'(bus.issueTag), 32'd1);
    tick();
    idle(1); #2;
    chk("t1_aluEN",    32'(bus.aluEN),    32'd1);
    chk("t1_aluData1", bus.aluData1,      32'd5);
    chk("t1_aluData2", bus.aluData2,      32'd7);
    chk("t1_aluTag",   32'(bus.aluTag),   32'd1);
    chk("t1_aluOp",    32'(bus.aluOp),    32'd0);
    chk("t1_busyTag",  32'(bus.issueTag), 32'd2);
    tick();
    bcast(1, 32'h1234); tick();
    idle(1); #2;
    chk("t1_freedTag", 32'(bus.issueTag), 32'd1);
    tick();

    // 2: pending Qj waits for CDB tag 4
    drive(1, 1, 4, 0, 0, 3, 0, 0, 0, 1); tick();
    idle(1); #2;
    chk("t2_wait_aluEN", 32'(bus.aluEN), 32'd0);
    tick();
    bcast(4, 10); #2;
    chk("t2_cdb_aluEN", 32'(bus.aluEN), 32'd0);
    tick();
    idle(1); #2;
    chk("t2_aluEN",    32'(bus.aluEN),  32'd1);
    chk("t2_aluData1", bus.aluData1,    32'd10);
    chk("t2_aluData2", bus.aluData2,    32'd3);
    chk("t2_aluOp",    32'(bus.aluOp),  32'd1);
    tick();
    bcast(1, 0); tick();

    // 3: same-cycle forwarding at issue
    drive(1, 0, 5, 0, 0, 2, 1, 5, 9, 1); tick();
    idle(1); #2;
    chk("t3_aluEN",    32'(bus.aluEN), 32'd1);
    chk("t3_aluData1", bus.aluData1,   32'd9);
    chk("t3_aluData2", bus.aluData2,   32'd2);
    tick();
    bcast(1, 0); tick();

    // 4: fill, drop when full, dispatch in order
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 32'(k + 1), 0, 32'(k + 11), 0, 0, 0, 0); tick();
    end
    idle(0); #2;
    chk("t4_full_ready", 32'(bus.issueReady), 32'd0);
    chk("t4_full_tag",   32'(bus.issueTag),   32'd0);
    drive(1, 1, 0, 99, 0, 99, 0, 0, 0, 0); tick();
    idle(1);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("t4_order_tag", 32'(bus.aluTag),  32'(k + 1));
      chk("t4_order_d1",  bus.aluData1,     32'(k + 1));
      tick();
    end

    // 5: free while full; concurrent issue is dropped
    drive(1, 0, 0, 55, 0, 66, 1, 2, 0, 1); #2;
    chk("t5_drop_ready", 32'(bus.issueReady), 32'd0);
    tick();
    idle(1); #2;
    chk("t5_issueTag",   32'(bus.issueTag),   32'd2);
    chk("t5_issueReady", 32'(bus.issueReady), 32'd1);
    chk("t5_aluEN",      32'(bus.aluEN),      32'd0);
    tick();
    bcast(1, 0); tick();
    bcast(3, 0); tick();

    // 6: reset overrides waiting and executing entries
    drive(1, 0, 6, 0, 0, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 4, 0, 8, 0, 0, 0, 0); tick();
    idle(1); #2;
    chk("t6_disp_tag", 32'(bus.aluTag), 32'd2);
    tick();
    RST = 1'b1;
    drive(1, 0, 0, 1, 0, 1, 1, 6, 77, 1); tick();
    RST = 1'b0;
    idle(1); #2;
    chk("t6_ready", 32'(bus.issueReady), 32'd1);
    chk("t6_tag",   32'(bus.issueTag),   32'd1);
    chk("t6_aluEN", 32'(bus.aluEN),      32'd0);
    tick();
    bcast(1, 5); tick();
    idle(1); #2;
    chk("t6_late_tag",   32'(bus.issueTag), 32'd1);
    chk("t6_late_aluEN", 32'(bus.aluEN),    32'd0);
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      RST = ($urandom_range(0, 59) == 0);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0, $urandom,
            ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0, $urandom,
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) != 0));
      tick();
    end
    RST = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/add_rs.md
Name: add_rs

Overview:
- Reservation station for the add/subtract functional unit; sits directly upstream of the pmf ALU state/datapath pair.
- Accepts issued add/sub instructions with operand values or producer tags.
- Snoops the common data bus (CDB) to resolve pending operands.
- Dispatches one ready entry per cycle to the ALU when the ALU reports available. Each entry stays busy until its own result tag appears on the CDB.

Parameters:
- ENTRIES, 3, number of station entries (1..7).
- TAG_W, 3, tag width. Tag 0 means "no dependence, value valid".
- DATA_W, 32, operand width.
- BASE_TAG, 1, tag of entry 0. Entry i owns tag BASE_TAG+i. BASE_TAG+ENTRIES-1 must be < 2^TAG_W, and BASE_TAG must be nonzero.

Ports:
- clk in 1: clock, rising edge.
- RST in 1: reset, synchronous, active-high.
- issueEN in 1: issue request.
- issueOp in 1: ALUAdd (0) / ALUSub (1).
- issueQj in TAG_W: producer tag of operand 1 (0 = ready).
- issueVj in DATA_W: operand 1 value, used when issueQj==0.
- issueQk in TAG_W: producer tag of operand 2 (0 = ready).
- issueVk in DATA_W: operand 2 value, used when issueQk==0.
- issueReady out 1: at least one free entry.
- issueTag out TAG_W: tag that will be allocated this cycle (lowest free entry). 0 when full.
- cdbValid in 1: CDB broadcast valid.
- cdbTag in TAG_W: broadcast tag.
- cdbData in DATA_W: broadcast value.
- aluAvailable in 1: ALU can accept an operation this cycle.
- aluEN out 1: dispatch strobe to ALU.
- aluOp out 1: op of dispatched entry.
- aluData1 out DATA_W: Vj of dispatched entry.
- aluData2 out DATA_W: Vk of dispatched entry.
- aluTag out TAG_W: tag of dispatched entry, carried to the CDB with the result.

Behaviour:
- Per-entry state: sFree, sWait (an operand is pending), sReady (both operands valid), sExec (dispatched, awaiting own CDB broadcast). Each entry stores op, Qj, Vj, Qk, Vk.
- Reset, on the clk edge with RST=1: all entries sFree, all Q fields 0, all V fields 0. After reset: issueReady=1, issueTag=BASE_TAG, aluEN=0, aluOp/aluData1/aluData2/aluTag=0. RST overrides any concurrent issue, CDB event or dispatch, including entries in sExec.
- Issue:
  - When issueEN && issueReady, the lowest-index free entry is written at the edge.
  - Issue with issueReady=0 is silently dropped.
  - issueReady and issueTag are combinational from registered state only. An entry freed at edge N is allocatable from cycle N+1.
- Same-cycle CDB forwarding at issue: if cdbValid && issueQj!=0 && cdbTag==issueQj, the entry stores Vj=cdbData, Qj=0. Qk is handled identically.
- New-entry state after issue: sReady if both Q fields are 0 after forwarding, else sWait.
- Wakeup: every entry in sWait with Qj==cdbTag (nonzero) under cdbValid captures Vj=cdbData, Qj=0; same for Qk. The entry moves to sReady when both Q fields become 0.
- Dispatch:
  - aluEN = aluAvailable && (some entry in sReady), combinational.
  - The selected entry is the lowest-index sReady entry. aluOp, aluData1, aluData2 and aluTag reflect that entry and are 0 when aluEN=0.
  - At the edge the selected entry moves to sExec.
  - Earliest dispatch is the cycle after issue. An entry woken at edge N dispatches no earlier than cycle N.
- Completion: an sExec entry whose tag equals cdbTag with cdbValid returns to sFree at the edge. A CDB match on an entry not in sExec does not free it.
- Simultaneous events are legal in one cycle: issue into entry A, wakeup of entry B, dispatch of entry C and free of entry D, all on distinct entries.
- Latency: issue to aluEN is 1 cycle minimum.
- Throughput: one issue and one dispatch per cycle.
- Width: all data is passed through unmodified. No arithmetic is performed in this block.

Decomposition:
- head.v additions:
  - ALUAdd/ALUSub encodings (already present).
  - sFree/sWait/sReady/sExec 2-bit encodings, named distinctly from the ALU's state encodings.
  - TAG_NONE=0.
- Sub-module rs_entry (one instance per entry): holds op/Q/V/state and does the CDB compare and capture. It has inputs alloc, dispatch and the CDB bus, and outputs ready, free and the stored fields.
- Top add_rs: priority encoders for allocate and dispatch, plus the output mux.

Test Plan:
1. Reset, then issue Add Qj=0 Vj=5 Qk=0 Vk=7 with aluAvailable=1. Expect issueTag=1 during issue; next cycle aluEN=1, aluData1=5, aluData2=7, aluTag=1, aluOp=0. Then a CDB broadcast of tag 1 frees the entry: issueTag=1 again the cycle after.
2. Issue Sub Qj=4 Vk=3 (Qk=0). Hold aluEN=0 until cdbValid tag=4 data=10. Next cycle aluEN=1, aluData1=10, aluData2=3, aluOp=1.
3. Issue Qj=5 in the same cycle as cdbValid tag=5 data=9. The next cycle dispatches with aluData1=9, proving the entry did not wait.
4. Three issues with aluAvailable=0. Expect issueReady=0 and issueTag=0. A fourth issue is dropped, with no entry change. Raise aluAvailable: entries dispatch in order tags 1, 2, 3 on consecutive cycles.
5. Fill with entries in sExec, then broadcast tag 2 and issue in the same cycle. The issue is dropped. The next cycle shows issueTag=2 and issueReady=1.
6. Assert RST with two entries in sWait/sExec. The next cycle has all free, issueReady=1, issueTag=1, aluEN=0. A later CDB tag 1 has no effect.
